// File: rtl/global_defs.sv
// Matrix dimension limits and register-file addressing widths shared across the MPU.
package global_defs;

    localparam int M               = 4;
    localparam int N               = 4;
    localparam int MBITS           = $clog2(M);
    localparam int NBITS           = $clog2(N);
    localparam int MATRIX_REG_BITS = 2;

endpackage

// File: rtl/mpu_data_types.sv
// Data types shared by the MPU load/store paths: float format, FSM states, size checks.
package mpu_data_types;

    import global_defs::*;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_sp;

    typedef enum logic [1:0] {
        STORE_IDLE,
        STORE_REQUEST,
        STORE_MATRIX,
        STORE_DONE
    } store_state_e;

    typedef enum logic [1:0] {
        LOAD_IDLE,
        LOAD_REQUEST,
        LOAD_MATRIX,
        LOAD_DONE
    } load_state_e;

    // A matrix transfer needs at least one element and must fit the register file.
    function automatic logic matrix_size_ok(input logic [MBITS:0] m, input logic [NBITS:0] n);
        return (m != '0) && (n != '0) &&
               (m <= (MBITS+1)'(M)) && (n <= (NBITS+1)'(N));
    endfunction

endpackage

// File: rtl/mpu_index_counter.sv
// Row-major (i,j) walker over an m x n matrix; wraps to (0,0) after the last element.
module mpu_index_counter
    import global_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [MBITS:0]   m,
    input  logic [NBITS:0]   n,
    output logic [MBITS:0]   i,
    output logic [NBITS:0]   j,
    output logic             last
);

    logic row_end;
    logic col_end;

    assign row_end = (i == m - (MBITS+1)'(1));
    assign col_end = (j == n - (NBITS+1)'(1));
    assign last    = row_end && col_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i <= '0;
            j <= '0;
        end else if (clear) begin
            i <= '0;
            j <= '0;
        end else if (advance) begin
            if (col_end) begin
                j <= '0;
                i <= row_end ? '0 : i + (MBITS+1)'(1);
            end else begin
                j <= j + (NBITS+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mpu_load.sv
// Matrix load engine: streams floats from memory into the matrix register file row-major.
module mpu_load
    import global_defs::*;
    import mpu_data_types::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_req_in,
    input  logic [MBITS:0]             mem_m_load_size_in,
    input  logic [NBITS:0]             mem_n_load_size_in,
    input  logic [MATRIX_REG_BITS:0]   mem_load_addr_in,
    input  logic                       mem_load_valid_in,
    input  float_sp                    mem_load_element_in,
    output logic                       mem_load_ack_out,
    input  logic                       reg_load_ready_in,
    output logic                       reg_load_req_out,
    output float_sp                    reg_load_element_out,
    output logic [MBITS:0]             reg_i_load_loc_out,
    output logic [NBITS:0]             reg_j_load_loc_out,
    output logic [MATRIX_REG_BITS:0]   reg_load_addr_out,
    output logic [MBITS:0]             reg_m_load_size_out,
    output logic [NBITS:0]             reg_n_load_size_out,
    output logic                       load_done_out,
    output logic                       load_error_out
);

    load_state_e     state;
    logic            ack;
    logic            ptr_clear;
    logic [MBITS:0]  row_ptr;
    logic [NBITS:0]  col_ptr;
    logic            ptr_last;

    // Ack is combinational so an element is consumed in the same cycle it is offered.
    assign ack              = (state == LOAD_MATRIX) && mem_load_valid_in;
    assign mem_load_ack_out = ack;
    assign ptr_clear        = (state != LOAD_MATRIX);

    mpu_index_counter u_index (
        .clk     (clk),
        .rst     (rst),
        .clear   (ptr_clear),
        .advance (ack),
        .m       (reg_m_load_size_out),
        .n       (reg_n_load_size_out),
        .i       (row_ptr),
        .j       (col_ptr),
        .last    (ptr_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= LOAD_IDLE;
            reg_load_req_out     <= 1'b0;
            reg_load_element_out <= '0;
            reg_i_load_loc_out   <= '0;
            reg_j_load_loc_out   <= '0;
            reg_load_addr_out    <= '0;
            reg_m_load_size_out  <= '0;
            reg_n_load_size_out  <= '0;
            load_done_out        <= 1'b0;
            load_error_out       <= 1'b0;
        end else begin
            reg_load_req_out <= 1'b0;
            load_done_out    <= 1'b0;
            load_error_out   <= 1'b0;

            case (state)
                LOAD_IDLE: begin
                    if (load_req_in) begin
                        reg_m_load_size_out <= mem_m_load_size_in;
                        reg_n_load_size_out <= mem_n_load_size_in;
                        reg_load_addr_out   <= mem_load_addr_in;
                        if (matrix_size_ok(mem_m_load_size_in, mem_n_load_size_in)) begin
                            state <= LOAD_REQUEST;
                        end else begin
                            load_error_out <= 1'b1;
                        end
                    end
                end

                LOAD_REQUEST: begin
                    if (reg_load_ready_in) begin
                        state <= LOAD_MATRIX;
                    end
                end

                // Done is raised alongside the final strobe, not a cycle after it.
                LOAD_MATRIX: begin
                    if (ack) begin
                        reg_load_req_out     <= 1'b1;
                        reg_load_element_out <= mem_load_element_in;
                        reg_i_load_loc_out   <= row_ptr;
                        reg_j_load_loc_out   <= col_ptr;
                        if (ptr_last) begin
                            load_done_out <= 1'b1;
                            state         <= LOAD_DONE;
                        end
                    end
                end

                LOAD_DONE: begin
                    state <= LOAD_IDLE;
                end

                default: begin
                    state <= LOAD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_load.sv
// Scoreboard bench for mpu_load: drivers push expected writes, a monitor pops them on each strobe.
module tb_mpu_load;

    import global_defs::*;
    import mpu_data_types::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     load_req_in;
    logic [MBITS:0]           mem_m_load_size_in;
    logic [NBITS:0]           mem_n_load_size_in;
    logic [MATRIX_REG_BITS:0] mem_load_addr_in;
    logic                     mem_load_valid_in;
    float_sp                  mem_load_element_in;
    logic                     mem_load_ack_out;
    logic                     reg_load_ready_in;
    logic                     reg_load_req_out;
    float_sp                  reg_load_element_out;
    logic [MBITS:0]           reg_i_load_loc_out;
    logic [NBITS:0]           reg_j_load_loc_out;
    logic [MATRIX_REG_BITS:0] reg_load_addr_out;
    logic [MBITS:0]           reg_m_load_size_out;
    logic [NBITS:0]           reg_n_load_size_out;
    logic                     load_done_out;
    logic                     load_error_out;

    typedef struct {
        logic [31:0] i;
        logic [31:0] j;
        logic [31:0] elem;
        logic [31:0] addr;
        logic [31:0] m;
        logic [31:0] n;
        logic        last;
    } write_t;

    write_t sb[$];
    int     vectors     = 0;
    int     miscompares = 0;
    logic   ack_pending = 1'b0;

    always #5 clk = ~clk;

    mpu_load dut (
        .clk                  (clk),
        .rst                  (rst),
        .load_req_in          (load_req_in),
        .mem_m_load_size_in   (mem_m_load_size_in),
        .mem_n_load_size_in   (mem_n_load_size_in),
        .mem_load_addr_in     (mem_load_addr_in),
        .mem_load_valid_in    (mem_load_valid_in),
        .mem_load_element_in  (mem_load_element_in),
        .mem_load_ack_out     (mem_load_ack_out),
        .reg_load_ready_in    (reg_load_ready_in),
        .reg_load_req_out     (reg_load_req_out),
        .reg_load_element_out (reg_load_element_out),
        .reg_i_load_loc_out   (reg_i_load_loc_out),
        .reg_j_load_loc_out   (reg_j_load_loc_out),
        .reg_load_addr_out    (reg_load_addr_out),
        .reg_m_load_size_out  (reg_m_load_size_out),
        .reg_n_load_size_out  (reg_n_load_size_out),
        .load_done_out        (load_done_out),
        .load_error_out       (load_error_out)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact single-precision encoding of a small positive integer.
    function automatic logic [31:0] int_to_float(input int v);
        int e = 0;
        while ((v >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((v - (1 << e)) << (23 - e))};
    endfunction

    // Every strobe must follow an ack by one cycle and match the oldest expected write.
    initial begin
        write_t e;
        forever begin
            @(posedge clk);
            #1;
            check_output("strobe_follows_ack", 32'(reg_load_req_out), 32'(ack_pending));
            ack_pending = 1'b0;
            if (reg_load_req_out) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_output("element", reg_load_element_out, e.elem);
                    check_output("row_i", 32'(reg_i_load_loc_out), e.i);
                    check_output("col_j", 32'(reg_j_load_loc_out), e.j);
                    check_output("addr", 32'(reg_load_addr_out), e.addr);
                    check_output("m_size", 32'(reg_m_load_size_out), e.m);
                    check_output("n_size", 32'(reg_n_load_size_out), e.n);
                    check_output("done_with_last", 32'(load_done_out), 32'(e.last));
                end
            end else begin
                check_output("done_without_strobe", 32'(load_done_out), 32'd0);
            end
        end
    end

    // valid_mode: 0 = held high, 1 = every other cycle, 2 = random gaps.
    task automatic apply_stimulus(input int m, input int n, input int addr, input int ready_delay,
                                  input int valid_mode, input bit ramp, input int stop_after);
        int          total;
        int          k;
        int          cycles;
        logic [31:0] elem;
        total = m * n;
        k     = 0;
        @(negedge clk);
        load_req_in        = 1'b1;
        mem_m_load_size_in = (MBITS+1)'(m);
        mem_n_load_size_in = (NBITS+1)'(n);
        mem_load_addr_in   = (MATRIX_REG_BITS+1)'(addr);
        reg_load_ready_in  = 1'b0;
        @(negedge clk);
        load_req_in         = 1'b0;
        elem                = ramp ? int_to_float(1) : $urandom;
        mem_load_valid_in   = 1'b1;
        mem_load_element_in = elem;
        for (int d = 0; d < ready_delay; d++) begin
            #4;
            check_output("ack_before_ready", 32'(mem_load_ack_out), 32'd0);
            @(negedge clk);
        end
        reg_load_ready_in = 1'b1;
        #4;
        check_output("ack_in_request", 32'(mem_load_ack_out), 32'd0);
        @(negedge clk);
        reg_load_ready_in = 1'b0;
        cycles = 0;
        while (k < total && k != stop_after && cycles < 400) begin
            case (valid_mode)
                0:       mem_load_valid_in = 1'b1;
                1:       mem_load_valid_in = (cycles % 2) == 0;
                default: mem_load_valid_in = $urandom_range(0, 3) != 0;
            endcase
            mem_load_element_in = elem;
            #4;
            check_output("ack_matches_valid", 32'(mem_load_ack_out), 32'(mem_load_valid_in));
            if (mem_load_ack_out) begin
                sb.push_back('{i: 32'(k / n), j: 32'(k % n), elem: elem, addr: 32'(addr),
                               m: 32'(m), n: 32'(n), last: (k == total - 1)});
                ack_pending = 1'b1;
                k++;
                elem = ramp ? int_to_float(k + 1) : $urandom;
            end
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 400) check_output("load_timeout", 32'd0, 32'd1);
        if (stop_after < 0) begin
            mem_load_valid_in = 1'b0;
            repeat (3) @(negedge clk);
            check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
            mem_load_valid_in = 1'b1;
            #4;
            check_output("ack_after_done", 32'(mem_load_ack_out), 32'd0);
            mem_load_valid_in = 1'b0;
        end
    endtask

    task automatic apply_error(input int m, input int n);
        @(negedge clk);
        load_req_in        = 1'b1;
        mem_m_load_size_in = (MBITS+1)'(m);
        mem_n_load_size_in = (NBITS+1)'(n);
        mem_load_addr_in   = (MATRIX_REG_BITS+1)'($urandom);
        @(negedge clk);
        load_req_in = 1'b0;
        check_output("error_pulse", 32'(load_error_out), 32'd1);
        mem_load_valid_in = 1'b1;
        reg_load_ready_in = 1'b1;
        #4;
        check_output("ack_after_error", 32'(mem_load_ack_out), 32'd0);
        @(negedge clk);
        check_output("error_single_pulse", 32'(load_error_out), 32'd0);
        mem_load_valid_in = 1'b0;
        reg_load_ready_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int rm;
        int rn;
        rst                 = 1'b0;
        load_req_in         = 1'b0;
        mem_m_load_size_in  = '0;
        mem_n_load_size_in  = '0;
        mem_load_addr_in    = '0;
        mem_load_valid_in   = 1'b0;
        mem_load_element_in = '0;
        reg_load_ready_in   = 1'b0;
        #1;
        check_output("reset_strobe", 32'(reg_load_req_out), 32'd0);
        check_output("reset_done", 32'(load_done_out), 32'd0);
        check_output("reset_error", 32'(load_error_out), 32'd0);
        check_output("reset_element", reg_load_element_out, 32'd0);
        check_output("reset_addr", 32'(reg_load_addr_out), 32'd0);
        check_output("reset_m", 32'(reg_m_load_size_out), 32'd0);
        check_output("reset_n", 32'(reg_n_load_size_out), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        apply_stimulus(2, 2, 1, 0, 0, 1'b1, -1);
        apply_stimulus(1, 1, 3, 0, 0, 1'b1, -1);
        apply_stimulus(M, N, 5, 0, 1, 1'b0, -1);
        apply_stimulus(3, 2, 2, 5, 0, 1'b0, -1);
        apply_error(0, 2);
        apply_error(2, N + 1);

        // Abort a 2x3 load after three writes and check the asynchronous clear.
        apply_stimulus(2, 3, 6, 0, 0, 1'b0, 3);
        rst = 1'b0;
        #1;
        check_output("rst_strobe_drop", 32'(reg_load_req_out), 32'd0);
        check_output("rst_ack_drop", 32'(mem_load_ack_out), 32'd0);
        check_output("rst_no_done", 32'(load_done_out), 32'd0);
        check_output("rst_size_clear", 32'(reg_m_load_size_out), 32'd0);
        repeat (2) @(negedge clk);
        mem_load_valid_in = 1'b0;
        rst = 1'b1;
        apply_stimulus(2, 3, 6, 0, 0, 1'b1, -1);

        for (int r = 0; r < 20; r++) begin
            rm = $urandom_range(0, 7);
            rn = $urandom_range(0, 7);
            if (rm >= 1 && rm <= M && rn >= 1 && rn <= N)
                apply_stimulus(rm, rn, $urandom_range(0, 7), $urandom_range(0, 3),
                               $urandom_range(0, 2), 1'b0, -1);
            else
                apply_error(rm, rn);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
